// File: rtl/mem_arb_pkg.sv
// mem_arbiter shared types
// state, owner and command-record encodings
package mem_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } owner_t;

  typedef struct packed {
    logic [7:0]  addr;
    logic        we_re;
    logic [3:0]  mask;
    logic [31:0] wdata;
  } cmd_t;

  localparam logic [3:0] FULL_MASK = 4'hF;

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter bus bundle
// IF port, LS port and memory side signals
interface mem_arbiter_if;

  logic        if_req;
  logic [7:0]  if_addr;
  logic        if_valid;
  logic        if_err;
  logic [31:0] if_rdata;

  logic        ls_req;
  logic [7:0]  ls_addr;
  logic        ls_we_re;
  logic [3:0]  ls_mask;
  logic [31:0] ls_wdata;
  logic        ls_valid;
  logic        ls_err;
  logic [31:0] ls_rdata;

  logic        mem_request;
  logic [7:0]  mem_address;
  logic [31:0] mem_w_data;
  logic [3:0]  mem_masking;
  logic        mem_we_re;
  logic        mem_valid;
  logic [31:0] mem_r_data;

  modport slave (
    input  if_req, if_addr,
    output if_valid, if_err, if_rdata,
    input  ls_req, ls_addr, ls_we_re,
    input  ls_mask, ls_wdata,
    output ls_valid, ls_err, ls_rdata,
    output mem_request, mem_address,
    output mem_w_data, mem_masking,
    output mem_we_re,
    input  mem_valid, mem_r_data
  );

  modport master (
    output if_req, if_addr,
    input  if_valid, if_err, if_rdata,
    output ls_req, ls_addr, ls_we_re,
    output ls_mask, ls_wdata,
    input  ls_valid, ls_err, ls_rdata,
    input  mem_request, mem_address,
    input  mem_w_data, mem_masking,
    input  mem_we_re,
    output mem_valid, mem_r_data
  );

endinterface

// File: rtl/mem_arbiter_arb_rr2.sv
// two-way round-robin pick
// bit 0 is IF, bit 1 is LS; a tie goes to the port that did not win last
module arb_rr2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  owner_t     last_owner,
  output logic       grant,
  output owner_t     winner
);

  // pick the winner for this cycle
  always_comb begin
    grant  = |req;
    winner = OWN_IF;
    unique case (1'b1)
      (req == 2'b11):
        winner = (last_owner == OWN_IF)
               ? OWN_LS : OWN_IF;
      (req == 2'b10):
        winner = OWN_LS;
      default:
        winner = OWN_IF;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter top: shares one memory port
// between instruction fetch and load/store
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);

  localparam logic [7:0] LIMIT =
    8'(TIMEOUT_CYCLES);

  state_t      state;
  owner_t      owner;
  owner_t      last_owner;
  cmd_t        cmd;
  logic [7:0]  cnt;
  cmd_t        if_cmd;
  cmd_t        ls_cmd;
  logic        grant;
  owner_t      winner;
  logic [31:0] rsp_data;

  assign if_cmd = '{
    addr:  bus.if_addr,
    we_re: 1'b0,
    mask:  FULL_MASK,
    wdata: '0
  };

  assign ls_cmd = '{
    addr:  bus.ls_addr,
    we_re: bus.ls_we_re,
    mask:  bus.ls_mask,
    wdata: bus.ls_wdata
  };

  assign rsp_data = cmd.we_re
                  ? '0 : bus.mem_r_data;

  assign bus.mem_address = cmd.addr;
  assign bus.mem_we_re   = cmd.we_re;
  assign bus.mem_masking = cmd.mask;
  assign bus.mem_w_data  = cmd.wdata;

  arb_rr2 u_rr (
    .req        ({bus.ls_req, bus.if_req}),
    .last_owner (last_owner),
    .grant      (grant),
    .winner     (winner)
  );

  // grant, hold one command, watchdog, route response
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      owner           <= OWN_IF;
      last_owner      <= OWN_LS;
      cmd             <= '0;
      cnt             <= '0;
      bus.mem_request <= 1'b0;
      bus.if_valid    <= 1'b0;
      bus.if_err      <= 1'b0;
      bus.if_rdata    <= '0;
      bus.ls_valid    <= 1'b0;
      bus.ls_err      <= 1'b0;
      bus.ls_rdata    <= '0;
    end else begin
      bus.if_valid <= 1'b0;
      bus.if_err   <= 1'b0;
      bus.if_rdata <= '0;
      bus.ls_valid <= 1'b0;
      bus.ls_err   <= 1'b0;
      bus.ls_rdata <= '0;
      unique case (state)
        IDLE: begin
          if (grant) begin
            cmd <= (winner == OWN_LS)
                 ? ls_cmd : if_cmd;
            owner           <= winner;
            last_owner      <= winner;
            cnt             <= '0;
            bus.mem_request <= 1'b1;
            state           <= BUSY;
          end
        end
        BUSY: begin
          if (bus.mem_valid) begin
            state           <= IDLE;
            bus.mem_request <= 1'b0;
            if (owner == OWN_IF) begin
              bus.if_valid <= 1'b1;
              bus.if_rdata <= rsp_data;
            end else begin
              bus.ls_valid <= 1'b1;
              bus.ls_rdata <= rsp_data;
            end
          end else if (cnt == LIMIT) begin
            state           <= IDLE;
            bus.mem_request <= 1'b0;
            if (owner == OWN_IF) begin
              bus.if_valid <= 1'b1;
              bus.if_err   <= 1'b1;
            end else begin
              bus.ls_valid <= 1'b1;
              bus.ls_err   <= 1'b1;
            end
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// mem_arbiter bench: memory model plus
// per-port expected-response scoreboard
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int T = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_arbiter_if bus ();

  mem_arbiter #(
    .TIMEOUT_CYCLES (T)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int mode  = 0;
  int seen  = 0;

  logic [31:0] mem_m [256];
  logic [31:0] ref_m [256];

  cmd_t        log_q [$];
  cmd_t        ifc_q [$];
  cmd_t        lsc_q [$];
  logic [31:0] if_q  [$];
  logic [31:0] ls_q  [$];

  function automatic logic [31:0] merge(
    input logic [31:0] old,
    input logic [31:0] wd,
    input logic [3:0]  m
  );
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++)
      if (m[b]) r[b*8 +: 8] = wd[b*8 +: 8];
    return r;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // memory answering one cycle after the request rises
  always @(negedge clk) begin
    if (mode == 0) begin
      if (bus.mem_request) begin
        seen = seen + 1;
        if (seen == 2) begin
          bus.mem_valid = 1'b1;
          log_q.push_back({bus.mem_address,
            bus.mem_we_re, bus.mem_masking,
            bus.mem_w_data});
          if (bus.mem_we_re) begin
            mem_m[bus.mem_address] =
              merge(mem_m[bus.mem_address],
                    bus.mem_w_data,
                    bus.mem_masking);
            bus.mem_r_data = 32'hBAD0BAD0;
          end else begin
            bus.mem_r_data =
              mem_m[bus.mem_address];
          end
        end else begin
          bus.mem_valid = 1'b0;
        end
      end else begin
        seen = 0;
        bus.mem_valid = 1'b0;
      end
    end
  end

  task automatic drive_if(input logic [7:0] a);
    bus.if_req  = 1'b1;
    bus.if_addr = a;
    ifc_q.push_back({a, 1'b0, 4'hF, 32'h0});
    if_q.push_back(ref_m[a]);
  endtask

  task automatic drive_ls(
    input logic [7:0]  a,
    input logic        we,
    input logic [3:0]  m,
    input logic [31:0] wd
  );
    bus.ls_req   = 1'b1;
    bus.ls_addr  = a;
    bus.ls_we_re = we;
    bus.ls_mask  = m;
    bus.ls_wdata = wd;
    lsc_q.push_back({a, we, m, wd});
    if (we) begin
      ref_m[a] = merge(ref_m[a], wd, m);
      ls_q.push_back(32'h0);
    end else begin
      ls_q.push_back(ref_m[a]);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({bus.mem_request, bus.mem_address,
         bus.mem_w_data, bus.mem_masking,
         bus.mem_we_re} !== 46'h0) begin
      n_bad++;
      $display("FAIL reset_mem: got req=%b addr=%h",
        bus.mem_request, bus.mem_address,
        " want all 0");
    end
    n_cmp++;
    if ({bus.if_valid, bus.if_err, bus.if_rdata,
         bus.ls_valid, bus.ls_err,
         bus.ls_rdata} !== 68'h0) begin
      n_bad++;
      $display("FAIL reset_rsp: got ifv=%b lsv=%b",
        bus.if_valid, bus.ls_valid, " want 0");
    end
    rst = 1'b0;
  endtask

  task automatic test_if_read();
    cmd_t got;
    cmd_t want;
    logic [31:0] wd;
    mem_m[8'h04] = 32'h00500093;
    ref_m[8'h04] = 32'h00500093;
    drive_if(8'h04);
    @(negedge clk);
    n_cmp++;
    if (bus.mem_request !== 1'b1) begin
      n_bad++;
      $display("FAIL if_req_rise: got %b want 1",
        bus.mem_request);
    end
    got = {bus.mem_address, bus.mem_we_re,
           bus.mem_masking, bus.mem_w_data};
    n_cmp++;
    if (got !== cmd_t'({8'h04, 1'b0, 4'hF,
                        32'h0})) begin
      n_bad++;
      $display("FAIL if_fields: got %h want %h",
        got, {8'h04, 1'b0, 4'hF, 32'h0});
    end
    @(negedge clk);
    n_cmp++;
    if (bus.if_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL if_early: got %b want 0",
        bus.if_valid);
    end
    @(negedge clk);
    wd = if_q.pop_front();
    want = ifc_q.pop_front();
    n_cmp++;
    if (bus.if_valid !== 1'b1 ||
        bus.if_rdata !== wd ||
        bus.if_err !== 1'b0) begin
      n_bad++;
      $display("FAIL if_rsp: got v=%b d=%h e=%b",
        bus.if_valid, bus.if_rdata, bus.if_err,
        " want v=1 d=%h e=0", wd);
    end
    n_cmp++;
    if (bus.ls_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL if_ls_quiet: got %b want 0",
        bus.ls_valid);
    end
    got = log_q.pop_front();
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL if_log: got %h want %h",
        got, want);
    end
    bus.if_req = 1'b0;
  endtask

  task automatic test_ls_write();
    int k;
    cmd_t got;
    cmd_t want;
    logic [31:0] wd;
    mem_m[8'h10] = 32'h11223344;
    ref_m[8'h10] = 32'h11223344;
    drive_ls(8'h10, 1'b1, 4'h3, 32'hDEADBEEF);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!bus.ls_valid && k < 20);
    wd = ls_q.pop_front();
    want = lsc_q.pop_front();
    n_cmp++;
    if (bus.ls_valid !== 1'b1 || k != 3) begin
      n_bad++;
      $display("FAIL ls_wr_lat: got %0d want 3", k);
    end
    n_cmp++;
    if (bus.ls_rdata !== wd ||
        bus.ls_err !== 1'b0 ||
        bus.if_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL ls_wr_rsp: got d=%h e=%b",
        bus.ls_rdata, bus.ls_err,
        " ifv=%b want d=%h e=0 ifv=0",
        bus.if_valid, wd);
    end
    got = log_q.pop_front();
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL ls_wr_log: got %h want %h",
        got, want);
    end
    bus.ls_req   = 1'b0;
    bus.ls_we_re = 1'b0;
  endtask

  task automatic test_round_robin();
    logic [7:0]  ia [3];
    logic [7:0]  la [3];
    logic        lw [3];
    logic [31:0] lwd [3];
    int ni, nl, done, last, budget, ci, cl;
    bit exp_ls;
    logic [31:0] gd;
    logic [31:0] wd;
    cmd_t got;
    cmd_t want;
    ia  = '{8'h20, 8'h21, 8'h22};
    la  = '{8'h10, 8'h30, 8'h31};
    lw  = '{1'b0, 1'b1, 1'b0};
    lwd = '{32'h0, 32'hCAFEF00D, 32'h0};
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    drive_if(ia[0]);
    drive_ls(la[0], lw[0], 4'hC, lwd[0]);
    ni = 1; nl = 1; done = 0;
    last = 0; budget = 0; ci = 0; cl = 0;
    while (done < 6 && budget < 60) begin
      @(negedge clk);
      budget++;
      if (bus.if_valid || bus.ls_valid) begin
        exp_ls = (done % 2) == 1;
        n_cmp++;
        if (bus.ls_valid !== exp_ls ||
            bus.if_valid !== !exp_ls) begin
          n_bad++;
          $display("FAIL rr_grant%0d: got ifv=%b",
            done, bus.if_valid,
            " lsv=%b want lsv=%b",
            bus.ls_valid, exp_ls);
        end
        if (bus.ls_valid) begin
          gd = bus.ls_rdata;
          wd = ls_q.pop_front();
          want = lsc_q.pop_front();
          cl++;
        end else begin
          gd = bus.if_rdata;
          wd = if_q.pop_front();
          want = ifc_q.pop_front();
          ci++;
        end
        n_cmp++;
        if (gd !== wd) begin
          n_bad++;
          $display("FAIL rr_data%0d: got %h want %h",
            done, gd, wd);
        end
        got = log_q.pop_front();
        n_cmp++;
        if (got !== want) begin
          n_bad++;
          $display("FAIL rr_log%0d: got %h want %h",
            done, got, want);
        end
        if (done > 0) begin
          n_cmp++;
          if (cyc - last != 3) begin
            n_bad++;
            $display("FAIL rr_rate%0d: got %0d want 3",
              done, cyc - last);
          end
        end
        last = cyc;
        done++;
        if (bus.if_valid) begin
          if (ni < 3) begin
            drive_if(ia[ni]);
            ni++;
          end else begin
            bus.if_req = 1'b0;
          end
        end else begin
          if (nl < 3) begin
            drive_ls(la[nl], lw[nl], 4'hC, lwd[nl]);
            nl++;
          end else begin
            bus.ls_req = 1'b0;
          end
        end
      end
    end
    n_cmp++;
    if (done != 6 || ci != 3 || cl != 3) begin
      n_bad++;
      $display("FAIL rr_count: got %0d/%0d/%0d",
        done, ci, cl, " want 6/3/3");
    end
    bus.if_req = 1'b0;
    bus.ls_req = 1'b0;
    bus.ls_we_re = 1'b0;
  endtask

  task automatic test_timeout();
    int k;
    bit bad;
    logic [31:0] wd;
    @(negedge clk);
    mode = 1;
    bus.mem_valid = 1'b0;
    bus.ls_req   = 1'b1;
    bus.ls_addr  = 8'h40;
    bus.ls_we_re = 1'b0;
    bus.ls_mask  = 4'hF;
    ls_q.push_back(32'h0);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!bus.mem_request && k < 10);
    bus.ls_addr = 8'h41;
    k = 0;
    do begin
      @(negedge clk);
      k++;
      if (k == 1) begin
        n_cmp++;
        if (bus.mem_address !== 8'h40) begin
          n_bad++;
          $display("FAIL to_frozen: got %h want 40",
            bus.mem_address);
        end
      end
    end while (!bus.ls_valid && k < 20);
    wd = ls_q.pop_front();
    n_cmp++;
    if (bus.ls_valid !== 1'b1 || k != T + 1) begin
      n_bad++;
      $display("FAIL to_lat: got %0d want %0d",
        k, T + 1);
    end
    n_cmp++;
    if (bus.ls_err !== 1'b1 ||
        bus.ls_rdata !== wd ||
        bus.if_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL to_rsp: got e=%b d=%h",
        bus.ls_err, bus.ls_rdata, " want e=1 d=0");
    end
    bus.ls_req = 1'b0;
    @(negedge clk);
    bus.mem_valid  = 1'b1;
    bus.mem_r_data = 32'hFFFF0000;
    @(negedge clk);
    bus.mem_valid = 1'b0;
    bad = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (bus.ls_valid !== 1'b0 ||
          bus.if_valid !== 1'b0 ||
          bus.mem_request !== 1'b0)
        bad = 1'b1;
    end
    n_cmp++;
    if (bad) begin
      n_bad++;
      $display("FAIL to_late: got pulse=1 want 0");
    end
  endtask

  task automatic test_reset_busy();
    int k;
    bit bad;
    logic [31:0] wd;
    cmd_t got;
    cmd_t want;
    bus.if_req  = 1'b1;
    bus.if_addr = 8'h60;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!bus.mem_request && k < 10);
    rst = 1'b1;
    bus.if_req = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({bus.mem_request, bus.mem_address,
         bus.mem_masking, bus.mem_we_re,
         bus.if_valid, bus.ls_valid} !== 16'h0) begin
      n_bad++;
      $display("FAIL rb_clear: got req=%b addr=%h",
        bus.mem_request, bus.mem_address,
        " want 0");
    end
    rst = 1'b0;
    bus.mem_valid  = 1'b1;
    bus.mem_r_data = 32'h12345678;
    @(negedge clk);
    bus.mem_valid = 1'b0;
    bad = 1'b0;
    repeat (2) begin
      if (bus.ls_valid !== 1'b0 ||
          bus.if_valid !== 1'b0 ||
          bus.mem_request !== 1'b0)
        bad = 1'b1;
      @(negedge clk);
    end
    n_cmp++;
    if (bad) begin
      n_bad++;
      $display("FAIL rb_stray: got pulse=1 want 0");
    end
    mode = 0;
    ref_m[8'h61] = mem_m[8'h61];
    ref_m[8'h62] = mem_m[8'h62];
    drive_if(8'h61);
    drive_ls(8'h62, 1'b0, 4'hF, 32'h0);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!bus.if_valid && !bus.ls_valid
               && k < 20);
    n_cmp++;
    if (bus.if_valid !== 1'b1 ||
        bus.ls_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL rb_tie: got ifv=%b lsv=%b",
        bus.if_valid, bus.ls_valid,
        " want ifv=1 lsv=0");
    end
    wd = if_q.pop_front();
    want = ifc_q.pop_front();
    got = log_q.pop_front();
    n_cmp++;
    if (bus.if_rdata !== wd || got !== want) begin
      n_bad++;
      $display("FAIL rb_if: got %h want %h",
        bus.if_rdata, wd);
    end
    bus.if_req = 1'b0;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!bus.ls_valid && k < 20);
    wd = ls_q.pop_front();
    want = lsc_q.pop_front();
    got = log_q.pop_front();
    n_cmp++;
    if (bus.ls_valid !== 1'b1 ||
        bus.ls_rdata !== wd || got !== want) begin
      n_bad++;
      $display("FAIL rb_ls: got v=%b d=%h",
        bus.ls_valid, bus.ls_rdata,
        " want v=1 d=%h", wd);
    end
    bus.ls_req = 1'b0;
  endtask

  task automatic test_timeout_tie();
    int k;
    logic [31:0] wd;
    @(negedge clk);
    mode = 1;
    bus.mem_valid = 1'b0;
    bus.ls_req   = 1'b1;
    bus.ls_addr  = 8'h50;
    bus.ls_we_re = 1'b0;
    bus.ls_mask  = 4'hF;
    ls_q.push_back(32'h13579BDF);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!bus.mem_request && k < 10);
    repeat (T) @(negedge clk);
    bus.mem_valid  = 1'b1;
    bus.mem_r_data = 32'h13579BDF;
    @(negedge clk);
    bus.mem_valid = 1'b0;
    wd = ls_q.pop_front();
    n_cmp++;
    if (bus.ls_valid !== 1'b1 ||
        bus.ls_err !== 1'b0 ||
        bus.ls_rdata !== wd) begin
      n_bad++;
      $display("FAIL tie_rsp: got v=%b e=%b d=%h",
        bus.ls_valid, bus.ls_err, bus.ls_rdata,
        " want v=1 e=0 d=%h", wd);
    end
    bus.ls_req = 1'b0;
    @(negedge clk);
    mode = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end want end");
    $fatal(1, "bench time limit");
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem_m[i] = {8'hC0, 8'(i), ~8'(i), 8'h5A};
      ref_m[i] = mem_m[i];
    end
    bus.if_req     = 1'b0;
    bus.if_addr    = '0;
    bus.ls_req     = 1'b0;
    bus.ls_addr    = '0;
    bus.ls_we_re   = 1'b0;
    bus.ls_mask    = '0;
    bus.ls_wdata   = '0;
    bus.mem_valid  = 1'b0;
    bus.mem_r_data = '0;
    test_reset();
    test_if_read();
    test_ls_write();
    test_round_robin();
    test_timeout();
    test_reset_busy();
    test_timeout_tie();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
      n_cmp, n_bad);
    $finish;
  end

endmodule
